// File: rtl/fp_dot_sequencer_if.sv
// fp_dot_sequencer_if
//   Bundles every non-clock/reset signal of the dot-product sequencer.
//   master : sequencer side (takes commands, drives RAM reads and FP cores)
//   slave  : environment side (command front end, operand RAM, FP cores)
//   Groups: cmd_* command/status, mem_* operand RAM read port,
//           mul_* / add_* stb/ack handshakes to the FP cores, core_rst.
interface fp_dot_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) ();
  logic              cmd_start;
  logic              cmd_abort;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [ADDR_W-1:0] cmd_addr_b;
  logic              cmd_busy;
  logic              cmd_done;
  logic [31:0]       cmd_result;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;

  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic              mul_a_stb;
  logic              mul_b_stb;
  logic              mul_a_ack;
  logic              mul_b_ack;
  logic [31:0]       mul_z;
  logic              mul_z_stb;
  logic              mul_z_ack;

  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic              add_a_stb;
  logic              add_b_stb;
  logic              add_a_ack;
  logic              add_b_ack;
  logic [31:0]       add_z;
  logic              add_z_stb;
  logic              add_z_ack;

  logic              core_rst;

  modport master (
    input  cmd_start, cmd_abort, cmd_len, cmd_addr_a, cmd_addr_b,
    output cmd_busy, cmd_done, cmd_result,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack,
    input  mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    output add_a, add_b, add_a_stb, add_b_stb, add_z_ack,
    input  add_a_ack, add_b_ack, add_z, add_z_stb,
    output core_rst
  );

  modport slave (
    output cmd_start, cmd_abort, cmd_len, cmd_addr_a, cmd_addr_b,
    input  cmd_busy, cmd_done, cmd_result,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack,
    output mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
    input  add_a, add_b, add_a_stb, add_b_stb, add_z_ack,
    output add_a_ack, add_b_ack, add_z, add_z_stb,
    input  core_rst
  );
endinterface

// File: rtl/fp_dot_sequencer.sv
// fp_dot_sequencer
//   Computes sum(a[i] * b[i]) for i < len by sequencing the shared FP
//   multiplier and adder cores over operands held in a single-port RAM.
//   Ports:
//     clk   system clock
//     reset asynchronous, active-high reset
//     bus   fp_dot_sequencer_if.master (command, RAM read, core handshakes,
//           core_rst abort pulse)
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | waiting for cmd_start; operands/counters latched on start
//   RD_A        | read a[addr_a + idx]
//   RD_B        | capture a operand, read b[addr_b + idx]
//   LAT_B       | capture b operand, raise multiplier strobes
//   MUL_ISSUE   | hold mul operands until both strobes are acked
//   MUL_WAIT    | accept product, raise adder strobes
//   ADD_ISSUE   | hold add operands (prod, acc) until both strobes acked
//   ADD_WAIT    | accept sum into acc, next element or finish
//   DONE        | publish acc to cmd_result, pulse cmd_done
module fp_dot_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input logic                clk,
  input logic                reset,
  fp_dot_sequencer_if.master bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD_A      = 4'd1;
  localparam logic [3:0] S_RD_B      = 4'd2;
  localparam logic [3:0] S_LAT_B     = 4'd3;
  localparam logic [3:0] S_MUL_ISSUE = 4'd4;
  localparam logic [3:0] S_MUL_WAIT  = 4'd5;
  localparam logic [3:0] S_ADD_ISSUE = 4'd6;
  localparam logic [3:0] S_ADD_WAIT  = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  logic [3:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_next;
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic [31:0]       acc;
  logic [31:0]       opa;
  logic [31:0]       opb;
  logic [31:0]       prod;
  logic [31:0]       result_q;
  logic              mul_a_stb_q;
  logic              mul_b_stb_q;
  logic              add_a_stb_q;
  logic              add_b_stb_q;
  logic              done_q;
  logic              core_rst_q;
  logic              mul_both_acked;
  logic              add_both_acked;

  // idx never reaches len, so idx + 1 cannot wrap even for the largest len.
  assign idx_next = idx + LEN_W'(1);

  // A strobe counts as acked once it has dropped, or while its ack is present.
  assign mul_both_acked = (!mul_a_stb_q || bus.mul_a_ack) && (!mul_b_stb_q || bus.mul_b_ack);
  assign add_both_acked = (!add_a_stb_q || bus.add_a_ack) && (!add_b_stb_q || bus.add_b_ack);

  always_comb begin
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    case (state)
      S_RD_A: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = addr_a_q + ADDR_W'(idx);
      end
      S_RD_B: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = addr_b_q + ADDR_W'(idx);
      end
      default: ;
    endcase
  end

  assign bus.cmd_busy   = (state != S_IDLE);
  assign bus.cmd_done   = done_q;
  assign bus.cmd_result = result_q;
  assign bus.mul_a      = opa;
  assign bus.mul_b      = opb;
  assign bus.mul_a_stb  = mul_a_stb_q;
  assign bus.mul_b_stb  = mul_b_stb_q;
  assign bus.mul_z_ack  = (state == S_MUL_WAIT);
  assign bus.add_a      = prod;
  assign bus.add_b      = acc;
  assign bus.add_a_stb  = add_a_stb_q;
  assign bus.add_b_stb  = add_b_stb_q;
  assign bus.add_z_ack  = (state == S_ADD_WAIT);
  assign bus.core_rst   = core_rst_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      idx         <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      prod        <= '0;
      result_q    <= '0;
      mul_a_stb_q <= 1'b0;
      mul_b_stb_q <= 1'b0;
      add_a_stb_q <= 1'b0;
      add_b_stb_q <= 1'b0;
      done_q      <= 1'b0;
      core_rst_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      core_rst_q <= 1'b0;
      // Abort outranks everything, including a final sum arriving this cycle.
      if (bus.cmd_abort && state != S_IDLE) begin
        state       <= S_IDLE;
        core_rst_q  <= 1'b1;
        mul_a_stb_q <= 1'b0;
        mul_b_stb_q <= 1'b0;
        add_a_stb_q <= 1'b0;
        add_b_stb_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.cmd_start) begin
              len_q    <= bus.cmd_len;
              addr_a_q <= bus.cmd_addr_a;
              addr_b_q <= bus.cmd_addr_b;
              idx      <= '0;
              acc      <= '0;
              state    <= (bus.cmd_len == '0) ? S_DONE : S_RD_A;
            end
          end
          S_RD_A: state <= S_RD_B;
          S_RD_B: begin
            opa   <= bus.mem_rd_data;
            state <= S_LAT_B;
          end
          S_LAT_B: begin
            opb         <= bus.mem_rd_data;
            mul_a_stb_q <= 1'b1;
            mul_b_stb_q <= 1'b1;
            state       <= S_MUL_ISSUE;
          end
          S_MUL_ISSUE: begin
            if (bus.mul_a_ack) mul_a_stb_q <= 1'b0;
            if (bus.mul_b_ack) mul_b_stb_q <= 1'b0;
            if (mul_both_acked) state <= S_MUL_WAIT;
          end
          S_MUL_WAIT: begin
            if (bus.mul_z_stb) begin
              prod        <= bus.mul_z;
              add_a_stb_q <= 1'b1;
              add_b_stb_q <= 1'b1;
              state       <= S_ADD_ISSUE;
            end
          end
          S_ADD_ISSUE: begin
            if (bus.add_a_ack) add_a_stb_q <= 1'b0;
            if (bus.add_b_ack) add_b_stb_q <= 1'b0;
            if (add_both_acked) state <= S_ADD_WAIT;
          end
          S_ADD_WAIT: begin
            if (bus.add_z_stb) begin
              acc   <= bus.add_z;
              idx   <= idx_next;
              state <= (idx_next == len_q) ? S_DONE : S_RD_A;
            end
          end
          S_DONE: begin
            result_q <= acc;
            done_q   <= 1'b1;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_dot_sequencer.sv
// tb_fp_dot_sequencer
//   Drives commands into fp_dot_sequencer, models the operand RAM and the
//   FP multiplier/adder cores (with adjustable ack/result delays) and
//   compares results against a dot product computed from RAM contents.
module tb_fp_dot_sequencer;

  logic clk;
  logic reset;

  fp_dot_sequencer_if #(.ADDR_W(8), .LEN_W(8)) bus ();

  fp_dot_sequencer #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---- single-precision helpers (exact for the small integers used here)
  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic real from_f32(input logic [31:0] f);
    logic [63:0] d;
    int e;
    if (f[30:0] == 31'h0) return 0.0;
    e = int'(f[30:23]) - 127 + 1023;
    d = {f[31], 11'(e), f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return to_f32(from_f32(a) * from_f32(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return to_f32(from_f32(a) + from_f32(b));
  endfunction

  function automatic int pick(input int d);
    return (d < 0) ? int'($urandom_range(0, 3)) : d;
  endfunction

  // ---- operand RAM: data appears one cycle after the read strobe
  logic [31:0] ram [256];
  logic [7:0]  rd_q[$];

  initial begin : ram_model
    logic [31:0] nxt;
    nxt = 32'h0;
    bus.mem_rd_data = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        nxt = 32'h0;
        bus.mem_rd_data = 32'h0;
      end else begin
        bus.mem_rd_data = nxt;
        if (bus.mem_rd_en) begin
          nxt = ram[bus.mem_rd_addr];
          rd_q.push_back(bus.mem_rd_addr);
        end
      end
    end
  end

  // ---- core delays (negative = random per transaction)
  int mul_a_dly, mul_b_dly, mul_z_dly, add_a_dly, add_b_dly, add_z_dly;
  int mul_txn, add_txn, stb_seen;

  initial begin : mul_core
    logic [31:0] va, vb, res;
    int ca, cb, cz;
    bit got_a, got_b, prev_a, prev_b, ackd_a, ackd_b, pend;
    {got_a, got_b, prev_a, prev_b, ackd_a, ackd_b, pend} = '0;
    ca = 0; cb = 0; cz = 0; va = 0; vb = 0; res = 0;
    bus.mul_a_ack = 0; bus.mul_b_ack = 0; bus.mul_z_stb = 0; bus.mul_z = 0;
    forever begin
      @(negedge clk);
      bus.mul_a_ack = 0; bus.mul_b_ack = 0; bus.mul_z_stb = 0;
      if (reset || bus.core_rst) begin
        {got_a, got_b, prev_a, prev_b, ackd_a, ackd_b, pend} = '0;
        continue;
      end
      if (bus.mul_a_stb || bus.mul_b_stb) stb_seen++;
      if (ackd_a) check_eq("mul_a_stb_drop", 32'(bus.mul_a_stb), 0);
      if (ackd_b) check_eq("mul_b_stb_drop", 32'(bus.mul_b_stb), 0);
      ackd_a = 0; ackd_b = 0;
      if (bus.mul_a_stb && !got_a) begin
        if (!prev_a) begin va = bus.mul_a; ca = pick(mul_a_dly); end
        else check_eq("mul_a_stable", bus.mul_a, va);
        if (ca == 0) begin bus.mul_a_ack = 1; got_a = 1; ackd_a = 1; end
        else ca--;
      end
      prev_a = bus.mul_a_stb;
      if (bus.mul_b_stb && !got_b) begin
        if (!prev_b) begin vb = bus.mul_b; cb = pick(mul_b_dly); end
        else check_eq("mul_b_stable", bus.mul_b, vb);
        if (cb == 0) begin bus.mul_b_ack = 1; got_b = 1; ackd_b = 1; end
        else cb--;
      end
      prev_b = bus.mul_b_stb;
      if (!pend) check_eq("mul_z_ack_idle", 32'(bus.mul_z_ack), 0);
      else if (cz == 0) begin
        bus.mul_z_stb = 1;
        bus.mul_z = res;
        if (bus.mul_z_ack) begin pend = 0; mul_txn++; end
      end else cz--;
      if (got_a && got_b) begin
        got_a = 0; got_b = 0; pend = 1;
        res = fmul(va, vb);
        cz = pick(mul_z_dly);
      end
    end
  end

  initial begin : add_core
    logic [31:0] va, vb, res;
    int ca, cb, cz;
    bit got_a, got_b, prev_a, prev_b, ackd_a, ackd_b, pend;
    {got_a, got_b, prev_a, prev_b, ackd_a, ackd_b, pend} = '0;
    ca = 0; cb = 0; cz = 0; va = 0; vb = 0; res = 0;
    bus.add_a_ack = 0; bus.add_b_ack = 0; bus.add_z_stb = 0; bus.add_z = 0;
    forever begin
      @(negedge clk);
      bus.add_a_ack = 0; bus.add_b_ack = 0; bus.add_z_stb = 0;
      if (reset || bus.core_rst) begin
        {got_a, got_b, prev_a, prev_b, ackd_a, ackd_b, pend} = '0;
        continue;
      end
      if (bus.add_a_stb || bus.add_b_stb) stb_seen++;
      if (ackd_a) check_eq("add_a_stb_drop", 32'(bus.add_a_stb), 0);
      if (ackd_b) check_eq("add_b_stb_drop", 32'(bus.add_b_stb), 0);
      ackd_a = 0; ackd_b = 0;
      if (bus.add_a_stb && !got_a) begin
        if (!prev_a) begin va = bus.add_a; ca = pick(add_a_dly); end
        else check_eq("add_a_stable", bus.add_a, va);
        if (ca == 0) begin bus.add_a_ack = 1; got_a = 1; ackd_a = 1; end
        else ca--;
      end
      prev_a = bus.add_a_stb;
      if (bus.add_b_stb && !got_b) begin
        if (!prev_b) begin vb = bus.add_b; cb = pick(add_b_dly); end
        else check_eq("add_b_stable", bus.add_b, vb);
        if (cb == 0) begin bus.add_b_ack = 1; got_b = 1; ackd_b = 1; end
        else cb--;
      end
      prev_b = bus.add_b_stb;
      if (!pend) check_eq("add_z_ack_idle", 32'(bus.add_z_ack), 0);
      else if (cz == 0) begin
        bus.add_z_stb = 1;
        bus.add_z = res;
        if (bus.add_z_ack) begin pend = 0; add_txn++; end
      end else cz--;
      if (got_a && got_b) begin
        got_a = 0; got_b = 0; pend = 1;
        res = fadd(va, vb);
        cz = pick(add_z_dly);
      end
    end
  end

  // ---- reference: dot product of the RAM vectors with single rounding per op
  function automatic logic [31:0] ref_dot(input int len, input logic [7:0] aa, input logic [7:0] ab);
    logic [31:0] s;
    logic [7:0] pa, pb;
    s = 32'h0;
    for (int i = 0; i < len; i++) begin
      pa = aa + 8'(i);
      pb = ab + 8'(i);
      s = fadd(fmul(ram[pa], ram[pb]), s);
    end
    return s;
  endfunction

  task automatic set_dly(input int ma, input int mb, input int mz, input int aa, input int ab, input int az);
    mul_a_dly = ma; mul_b_dly = mb; mul_z_dly = mz;
    add_a_dly = aa; add_b_dly = ab; add_z_dly = az;
  endtask

  task automatic start_cmd(input int len, input logic [7:0] aa, input logic [7:0] ab);
    rd_q.delete();
    mul_txn = 0; add_txn = 0; stb_seen = 0;
    @(negedge clk);
    bus.cmd_len = 8'(len);
    bus.cmd_addr_a = aa;
    bus.cmd_addr_b = ab;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    check_eq("busy_after_start", 32'(bus.cmd_busy), 1);
  endtask

  task automatic run_cmd(input int len, input logic [7:0] aa, input logic [7:0] ab,
                         input bit poke, output logic [31:0] res, output int cyc);
    logic [31:0] expv;
    logic [7:0] ea;
    int n;
    expv = ref_dot(len, aa, ab);
    start_cmd(len, aa, ab);
    n = 1;
    while (!bus.cmd_done && n < 3000) begin
      bus.cmd_start = poke && (n == 8);
      if (poke && n == 8) begin
        bus.cmd_len = 8'd5; bus.cmd_addr_a = 8'h80; bus.cmd_addr_b = 8'h90;
      end
      @(negedge clk);
      n++;
    end
    bus.cmd_start = 1'b0;
    check_eq("done_seen", 32'(bus.cmd_done), 1);
    check_eq("result", bus.cmd_result, expv);
    res = bus.cmd_result;
    cyc = n;
    @(negedge clk);
    check_eq("done_one_cycle", 32'(bus.cmd_done), 0);
    check_eq("busy_after_done", 32'(bus.cmd_busy), 0);
    check_eq("result_held", bus.cmd_result, expv);
    check_eq("rd_count", 32'(rd_q.size()), 32'(2 * len));
    for (int i = 0; i < len && 2 * i + 1 < rd_q.size(); i++) begin
      ea = aa + 8'(i);
      check_eq("rd_addr_a", 32'(rd_q[2 * i]), 32'(ea));
      ea = ab + 8'(i);
      check_eq("rd_addr_b", 32'(rd_q[2 * i + 1]), 32'(ea));
    end
    check_eq("mul_txn", 32'(mul_txn), 32'(len));
    check_eq("add_txn", 32'(add_txn), 32'(len));
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] exp_result);
    check_eq({tag, "_busy"}, 32'(bus.cmd_busy), 0);
    check_eq({tag, "_done"}, 32'(bus.cmd_done), 0);
    check_eq({tag, "_result"}, bus.cmd_result, exp_result);
    check_eq({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    check_eq({tag, "_stbs"}, 32'({bus.mul_a_stb, bus.mul_b_stb, bus.add_a_stb, bus.add_b_stb}), 0);
    check_eq({tag, "_z_acks"}, 32'({bus.mul_z_ack, bus.add_z_ack}), 0);
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 256; i++) ram[i] = to_f32(real'($urandom_range(0, 9)));
  endtask

  initial begin : main
    logic [31:0] res, prev_res;
    int cyc, n, dones;
    logic [7:0] ra, rb;
    int rl;

    checks = 0; failures = 0;
    bus.cmd_start = 0; bus.cmd_abort = 0; bus.cmd_len = 0;
    bus.cmd_addr_a = 0; bus.cmd_addr_b = 0;
    set_dly(0, 0, 0, 0, 0, 0);
    fill_ram();
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset", 32'h0);
    check_eq("reset_core_rst", 32'(bus.core_rst), 0);
    check_eq("reset_add_b", bus.add_b, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 2.0 * 3.0
    ram[8'h10] = 32'h40000000;
    ram[8'h20] = 32'h40400000;
    run_cmd(1, 8'h10, 8'h20, 1'b0, res, cyc);
    check_eq("len1_value", res, 32'h40C00000);

    // [1,2,3] . [4,5,6] = 32
    ram[8'h00] = 32'h3F800000; ram[8'h01] = 32'h40000000; ram[8'h02] = 32'h40400000;
    ram[8'h40] = 32'h40800000; ram[8'h41] = 32'h40A00000; ram[8'h42] = 32'h40C00000;
    run_cmd(3, 8'h00, 8'h40, 1'b0, res, cyc);
    check_eq("len3_value", res, 32'h42000000);

    // empty vector
    run_cmd(0, 8'h33, 8'h44, 1'b0, res, cyc);
    check_eq("len0_latency", 32'(cyc), 2);
    check_eq("len0_value", res, 32'h0);
    check_eq("len0_no_strobes", 32'(stb_seen), 0);

    // a vector wraps past the top of the RAM
    run_cmd(3, 8'hFE, 8'h50, 1'b0, res, cyc);

    // slow operand acks, stray start mid-run
    set_dly(0, 5, 1, 3, 0, 2);
    run_cmd(4, 8'h60, 8'h70, 1'b1, res, cyc);

    // abort while waiting for a product
    prev_res = res;
    set_dly(0, 0, 20, 0, 0, 0);
    start_cmd(2, 8'h08, 8'h18);
    n = 0;
    while (!bus.mul_z_ack && n < 200) begin @(negedge clk); n++; end
    check_eq("abort_reached_mul_wait", 32'(bus.mul_z_ack), 1);
    bus.cmd_abort = 1'b1;
    @(negedge clk);
    bus.cmd_abort = 1'b0;
    check_eq("abort_core_rst", 32'(bus.core_rst), 1);
    check_idle_outputs("abort", prev_res);
    dones = 0;
    @(negedge clk);
    check_eq("abort_core_rst_pulse", 32'(bus.core_rst), 0);
    repeat (30) begin
      if (bus.cmd_done) dones++;
      @(negedge clk);
    end
    check_eq("abort_no_done", 32'(dones), 0);
    check_eq("abort_result_kept", bus.cmd_result, prev_res);
    set_dly(0, 0, 0, 0, 0, 0);
    run_cmd(1, 8'h10, 8'h20, 1'b0, res, cyc);
    check_eq("after_abort_value", res, 32'h40C00000);

    // asynchronous reset mid-operation
    set_dly(-1, -1, -1, -1, -1, -1);
    start_cmd(5, 8'h30, 8'hA0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset", 32'h0);
    check_eq("async_reset_core_rst", 32'(bus.core_rst), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // randomized runs with random core timing
    for (int t = 0; t < 12; t++) begin
      fill_ram();
      rl = int'($urandom_range(1, 8));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_cmd(rl, ra, rb, 1'($urandom_range(0, 1)), res, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
